// File: rtl/myio_pkg.sv
// myio_pkg: register map, field positions, FSM states and config struct shared by the LED controller
package myio_pkg;
  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_DUTY = 2'd1;
  localparam logic [1:0] REG_BLINK = 2'd2;
  localparam int CTRL_EN = 0;
  localparam int CTRL_LED_EN = 1;
  localparam int CTRL_BLINK_EN = 4;
  localparam int CTRL_PRESCALE = 16;
  typedef enum logic {ST_OFF, ST_RUN} state_t;
  typedef struct packed {
    logic        en;
    logic [2:0]  led_en;
    logic [2:0]  blink_en;
    logic [15:0] prescale;
    logic [23:0] duty;
    logic [15:0] half;
  } cfg_t;
  function automatic cfg_t cfg_write(input cfg_t c, input logic [1:0] a, input logic [31:0] d);
    cfg_t r;
    r = c;
    if (a == REG_CTRL) begin
      r.en = d[CTRL_EN];
      r.led_en = d[CTRL_LED_EN +: 3];
      r.blink_en = d[CTRL_BLINK_EN +: 3];
      r.prescale = d[CTRL_PRESCALE +: 16];
    end
    if (a == REG_DUTY) r.duty = d[23:0];
    if (a == REG_BLINK) r.half = d[15:0];
    return r;
  endfunction
endpackage

// File: rtl/myio_pwm_timebase.sv
// myio_pwm_timebase: prescaler and 8-bit PWM counter producing tick and period-end strobes
module myio_pwm_timebase (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [15:0] prescale,
  output logic        tick,
  output logic [7:0]  pwm_cnt,
  output logic        pe
);
  logic [15:0] pre_cnt;
  assign tick = run && pre_cnt == prescale;
  assign pe = tick && pwm_cnt == 8'hff;
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 16'd1;
      pwm_cnt <= tick ? pwm_cnt + 8'd1 : pwm_cnt;
    end
  end
endmodule

// File: rtl/myio_led_ctrl.sv
// myio_led_ctrl: double-buffered PWM/blink LED controller with status word
module myio_led_ctrl
  import myio_pkg::*;
#(
  parameter int NUM_LED = 3
) (
  input  logic               ACLK,
  input  logic               ARESET,
  input  logic               cfg_wr,
  input  logic [1:0]         cfg_addr,
  input  logic [31:0]        cfg_data,
  output logic [NUM_LED-1:0] led_o,
  output logic [31:0]        stat_o
);
  state_t state, state_nxt;
  cfg_t stg, stg_nxt, act;
  logic tick, pe, period_end, run, blink_phase, blink_wrap;
  logic [7:0] pwm_cnt;
  logic [15:0] blink_cnt, pe_cnt;
  logic [NUM_LED-1:0] led_nxt;
  assign run = state == ST_RUN;
  assign period_end = tick && pe;
  assign blink_wrap = act.half == '0 || blink_cnt == act.half - 16'd1;
  myio_pwm_timebase u_tb (
    .clk(ACLK),
    .rst(ARESET),
    .run(run),
    .prescale(act.prescale),
    .tick(tick),
    .pwm_cnt(pwm_cnt),
    .pe(pe)
  );
  for (genvar i = 0; i < NUM_LED; i++) begin : g_led
    assign led_nxt[i] = run && act.led_en[i] && pwm_cnt < act.duty[8*i +: 8] && (blink_phase || !act.blink_en[i]);
  end
  always_comb begin
    stg_nxt = cfg_wr ? cfg_write(stg, cfg_addr, cfg_data) : stg;
    state_nxt = act.en ? ST_RUN : ST_OFF;
  end
  always_ff @(posedge ACLK) begin
    if (ARESET) state <= ST_OFF;
    else state <= state_nxt;
  end
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      stg <= '0;
      act <= '0;
      blink_cnt <= '0;
      blink_phase <= 1'b1;
      pe_cnt <= '0;
      led_o <= '0;
      stat_o <= '0;
    end else begin
      stg <= stg_nxt;
      if (!run) act <= stg_nxt;
      else if (period_end) act <= stg;
      led_o <= led_nxt;
      stat_o <= {13'd0, run, stg != act, blink_phase, pe_cnt};
      if (!run) begin
        blink_cnt <= '0;
        blink_phase <= 1'b1;
      end else if (period_end) begin
        pe_cnt <= pe_cnt + 16'd1;
        blink_cnt <= blink_wrap ? '0 : blink_cnt + 16'd1;
        blink_phase <= act.half == '0 ? 1'b1 : blink_wrap ? ~blink_phase : blink_phase;
      end
    end
  end
endmodule

// File: tb/tb_myio_led_ctrl.sv
// tb_myio_led_ctrl: randomized scoreboard bench against a period-arithmetic reference model
module tb_myio_led_ctrl;
  logic ACLK = 1'b0;
  logic ARESET, cfg_wr;
  logic [1:0] cfg_addr;
  logic [31:0] cfg_data;
  logic [2:0] led_o;
  logic [31:0] stat_o;
  int checks = 0, errors = 0;
  typedef struct {
    logic [2:0]  led;
    logic [31:0] stat;
  } exp_t;
  exp_t q[$];
  localparam logic [31:0] CM = 32'hFFFF_007F, DM = 32'h00FF_FFFF, BM = 32'h0000_FFFF;
  logic [31:0] s_ctrl, s_duty, s_blink, a_ctrl, a_duty, a_blink;
  bit m_run, m_phase;
  int m_cyc, m_bper;
  logic [31:0] m_pecnt;
  logic [2:0] m_led;
  logic [31:0] m_stat;
  myio_led_ctrl #(.NUM_LED(3)) dut (
    .ACLK(ACLK),
    .ARESET(ARESET),
    .cfg_wr(cfg_wr),
    .cfg_addr(cfg_addr),
    .cfg_data(cfg_data),
    .led_o(led_o),
    .stat_o(stat_o)
  );
  always #5 ACLK = ~ACLK;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask
  always @(negedge ACLK) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("led_o", {29'd0, led_o}, {29'd0, e.led});
      check("stat_o", stat_o, e.stat);
    end
  end
  task automatic model(input logic r, input logic w, input logic [1:0] a, input logic [31:0] d);
    int per, pwm, half;
    bit pe, run_next;
    logic [31:0] n_ctrl, n_duty, n_blink;
    if (r) begin
      {s_ctrl, s_duty, s_blink, a_ctrl, a_duty, a_blink} = '0;
      m_run = 0; m_phase = 1; m_cyc = 0; m_bper = 0; m_pecnt = 0; m_led = 0; m_stat = 0;
      return;
    end
    per = int'(a_ctrl >> 16) + 1;
    pwm = m_cyc / per;
    pe = m_run && m_cyc == 256 * per - 1;
    for (int i = 0; i < 3; i++)
      m_led[i] = m_run && a_ctrl[1+i] && pwm < int'((a_duty >> (8*i)) & 255) && (m_phase || !a_ctrl[4+i]);
    m_stat = {13'd0, m_run, (s_ctrl != a_ctrl) || (s_duty != a_duty) || (s_blink != a_blink), m_phase, m_pecnt[15:0]};
    n_ctrl = (w && a == 0) ? d & CM : s_ctrl;
    n_duty = (w && a == 1) ? d & DM : s_duty;
    n_blink = (w && a == 2) ? d & BM : s_blink;
    half = int'(a_blink);
    run_next = a_ctrl[0];
    if (!m_run) begin
      m_bper = 0; m_phase = 1; m_cyc = 0;
      {a_ctrl, a_duty, a_blink} = {n_ctrl, n_duty, n_blink};
    end else if (pe) begin
      m_pecnt++;
      m_cyc = 0;
      if (half == 0) begin m_phase = 1; m_bper = 0; end
      else if (++m_bper == half) begin m_bper = 0; m_phase = !m_phase; end
      {a_ctrl, a_duty, a_blink} = {s_ctrl, s_duty, s_blink};
    end else m_cyc++;
    {s_ctrl, s_duty, s_blink} = {n_ctrl, n_duty, n_blink};
    m_run = run_next;
  endtask
  task automatic step(input logic r, input logic w, input logic [1:0] a, input logic [31:0] d);
    ARESET = r; cfg_wr = w; cfg_addr = a; cfg_data = d;
    @(posedge ACLK);
    model(r, w, a, d);
    q.push_back('{m_led, m_stat});
    #1;
    ARESET = 0; cfg_wr = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0);
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    step(0, 1, a, d);
  endtask
  task automatic wait_pe(output int n);
    logic [15:0] v;
    v = stat_o[15:0];
    n = 0;
    while (stat_o[15:0] == v && n < 3000) begin idle(1); n++; end
  endtask
  task automatic first_rise(input string name);
    int first;
    first = -1;
    wr(0, 32'h0000_000F);
    for (int k = 1; k <= 6; k++) begin
      idle(1);
      if (first < 0 && led_o[0]) first = k;
    end
    check(name, first, 2);
  endtask
  initial begin
    int n, hi;
    logic [15:0] v0;
    ARESET = 1; cfg_wr = 0; cfg_addr = 0; cfg_data = 0;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("reset_led", {29'd0, led_o}, 0);
    check("reset_stat", stat_o, 0);
    wr(1, 32'h0000_0080);
    first_rise("first_rise");
    hi = 0;
    for (int k = 0; k < 256; k++) begin idle(1); hi += int'(led_o[0]); end
    check("duty128_high", hi, 128);
    wr(0, 32'h0003_000F);
    wait_pe(n);
    wait_pe(n);
    v0 = stat_o[15:0];
    wait_pe(n);
    check("pe_spacing", n, 1024);
    check("pe_increment", {16'd0, stat_o[15:0]}, {16'd0, v0 + 16'd1});
    wr(0, 32'h0000_000F);
    wait_pe(n);
    wait_pe(n);
    wr(1, 32'h0000_0040);
    wait_pe(n);
    wait_pe(n);
    idle(100);
    wr(1, 32'h0000_00C0);
    idle(1);
    check("stage_differs", {31'd0, stat_o[17]}, 1);
    wr(2, 32'h0000_0002);
    wr(0, 32'h0000_007F);
    idle(1500);
    wr(0, 32'h0);
    idle(2);
    check("ctrl0_still_run", {31'd0, stat_o[18]}, 1);
    wait_pe(n);
    idle(3);
    check("off_state", {31'd0, stat_o[18]}, 0);
    check("off_led", {29'd0, led_o}, 0);
    wr(0, 32'h0000_000F);
    idle(300);
    step(1, 1, 0, 32'h0000_000F);
    check("rst_wr_led", {29'd0, led_o}, 0);
    check("rst_wr_stat", stat_o, 0);
    wr(1, 32'h0000_0080);
    first_rise("restart_rise");
    for (int t = 0; t < 40; t++) begin
      int op;
      logic [1:0] a;
      logic [31:0] d;
      op = $urandom_range(0, 14);
      a = 2'($urandom_range(0, 3));
      d = $urandom;
      if (op == 0) step(1, 1'($urandom_range(0, 1)), a, d);
      else begin
        if (a == 0) d = {16'($urandom_range(0, 2)), d[15:1], 1'($urandom_range(0, 4) != 0)};
        if (a == 2) d = 32'($urandom_range(0, 3));
        wr(a, d);
      end
      idle($urandom_range(1, 700));
    end
    idle(2);
    @(negedge ACLK);
    #1;
    check("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
